// File: rtl/zr_fetch_pkg.sv
// zr_fetch_pkg: shared types and defaults for the instruction fetch queue
package zr_fetch_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int MAX_OUT_DEF = 2;
  typedef enum logic {IDLE, RUN} state_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/zr_fetch_fifo.sv
// zr_fetch_fifo: synchronous FIFO of fetch_entry_t with flush.
// Ports: clk, rst_n (async active-low); push/din write; pop reads dout (head);
// flush empties the queue and wins over push/pop; full, empty, count status.
module zr_fetch_fifo
  import zr_fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic w_en, r_en;
  always_comb begin
    count = wr_q - rd_q;
    empty = wr_q == rd_q;
    full = count == DEPTH[AW:0];
    r_en = pop && !empty && !flush;
    // a push into a full queue is only legal when the head leaves in the same cycle
    w_en = push && !flush && (!full || r_en);
    wr_d = flush ? '0 : wr_q + {{AW{1'b0}}, w_en};
    rd_d = flush ? '0 : rd_q + {{AW{1'b0}}, r_en};
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (w_en) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/zr_fetch_queue.sv
// zr_fetch_queue: instruction prefetch queue between a memory read port and the core.
// Ports: clk, rst_n (async active-low); fetch_en, branch, branch_addr from the core;
// fetch_valid/fetch_ready/fetch_rdata/fetch_addr head-of-queue handshake to the core;
// instr_req/instr_addr/instr_gnt/instr_rvalid/instr_rdata memory request/response port.
// Option: define FETCH_QUEUE_BYPASS_EN to present a response directly when the queue is empty.
module zr_fetch_queue
  import zr_fetch_pkg::*;
#(
  parameter int          DEPTH     = DEPTH_DEF,
  parameter int          MAX_OUT   = MAX_OUT_DEF,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_rdata,
  output logic [31:0] fetch_addr,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_rdata
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d, rsp_addr_q, rsp_addr_d, tgt;
  logic [1:0] out_q, out_d, disc_q, disc_d;
  logic rv_ok, fire, accept, push, pop, full, empty, unused_bits;
  logic [AW:0] cnt;
  fetch_entry_t head, dout;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
`endif
  zr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(branch),
    .din({rsp_addr_q, instr_rdata}), .dout(dout), .full(full), .empty(empty), .count(cnt)
  );
  assign unused_bits = ^branch_addr[1:0];
  always_comb begin
    tgt = {branch_addr[31:2], 2'b00};
    state_d = fetch_en ? RUN : IDLE;
    rv_ok = instr_rvalid && out_q != '0;
    // reserve queue space for every outstanding response so a push never overflows
    instr_req = state_q == RUN && !branch && int'(out_q) < MAX_OUT && int'(cnt) + int'(out_q) < DEPTH;
    instr_addr = req_addr_q;
    fire = instr_req && instr_gnt;
    accept = rv_ok && disc_q == '0 && !branch;
    out_d = out_q + {1'b0, fire} - {1'b0, rv_ok};
    // a response landing in the branch cycle is already stale, so it is not counted as pending
    disc_d = branch ? out_q - {1'b0, rv_ok} : disc_q - {1'b0, rv_ok && disc_q != '0};
    req_addr_d = branch ? tgt : fire ? req_addr_q + 32'd4 : req_addr_q;
    rsp_addr_d = branch ? tgt : accept ? rsp_addr_q + 32'd4 : rsp_addr_q;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = accept && empty;
    fetch_valid = !empty || byp;
    head = empty ? {rsp_addr_q, instr_rdata} : dout;
    push = accept && !(byp && fetch_ready);
`else
    fetch_valid = !empty;
    head = dout;
    push = accept;
`endif
    pop = fetch_ready && !empty;
    fetch_rdata = fetch_valid ? head.data : '0;
    fetch_addr = fetch_valid ? head.addr : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_addr_q <= BOOT_ADDR;
      rsp_addr_q <= BOOT_ADDR;
      out_q <= '0;
      disc_q <= '0;
    end else begin
      state_q <= state_d;
      req_addr_q <= req_addr_d;
      rsp_addr_q <= rsp_addr_d;
      out_q <= out_d;
      disc_q <= disc_d;
    end
  end
  a_rvalid_protocol: assert property (@(posedge clk) disable iff (!rst_n) instr_rvalid |-> out_q != '0);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push && !branch |-> !full || pop);
endmodule

// File: tb/tb_zr_fetch_queue.sv
// tb_zr_fetch_queue: directed checks of the fetch queue against hand-computed values
module tb_zr_fetch_queue;
  logic clk = 1'b0, rst_n = 1'b0, fetch_en = 1'b0, branch = 1'b0, fetch_ready = 1'b0;
  logic instr_gnt = 1'b0, instr_rvalid = 1'b0, rsp_en = 1'b1;
  logic [31:0] branch_addr = '0, instr_rdata = '0;
  logic fetch_valid, instr_req;
  logic [31:0] fetch_rdata, fetch_addr, instr_addr;
  logic [31:0] pq[$];
  logic [63:0] cap[$];
  int n_tests = 0, n_fail = 0, n_gnt = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic [31:0] BYP = 32'd1;
`else
  localparam logic [31:0] BYP = 32'd0;
`endif
  always #5 clk = ~clk;
  zr_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .branch(branch), .branch_addr(branch_addr),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_rdata(fetch_rdata),
    .fetch_addr(fetch_addr), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_cap(input string tag, input int i, input logic [31:0] a);
    logic [63:0] e;
    if (cap.size() > i) begin
      e = cap[i];
      chk({tag, "_addr"}, e[63:32], a);
      chk({tag, "_data"}, e[31:0], ~a);
    end else chk({tag, "_missing"}, 32'(cap.size()), 32'(i + 1));
  endtask
  task automatic tick();
    #1;
    if (instr_req && instr_gnt) begin
      pq.push_back(instr_addr);
      n_gnt++;
    end
    if (fetch_valid && fetch_ready) cap.push_back({fetch_addr, fetch_rdata});
    @(posedge clk);
    @(negedge clk);
    if (rsp_en && pq.size() > 0) begin
      instr_rvalid = 1'b1;
      instr_rdata = ~pq.pop_front();
    end else begin
      instr_rvalid = 1'b0;
      instr_rdata = '0;
    end
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    {fetch_en, branch, fetch_ready, instr_gnt, instr_rvalid} = '0;
    rsp_en = 1'b1;
    instr_rdata = '0;
    pq.delete();
    cap.delete();
    n_gnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(instr_req), 0);
    chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_rdata", fetch_rdata, 0);
    chk("rst_faddr", fetch_addr, 0);
    chk("rst_iaddr", instr_addr, 32'h80);
    // back-to-back fetch with immediate grant and 1-cycle response
    do_reset();
    {fetch_en, instr_gnt, fetch_ready} = 3'b111;
    chk("c0_req", 32'(instr_req), 0);
    tick();
    chk("c1_req", 32'(instr_req), 1);
    chk("c1_addr", instr_addr, 32'h80);
    chk("c1_valid", 32'(fetch_valid), 0);
    tick();
    chk("c2_req", 32'(instr_req), 1);
    chk("c2_addr", instr_addr, 32'h84);
    chk("c2_valid", 32'(fetch_valid), BYP);
    tick();
    chk("c3_addr", instr_addr, 32'h88);
    chk("c3_valid", 32'(fetch_valid), 1);
    repeat (6) tick();
    for (int i = 0; i < 3; i++) chk_cap("seq", i, 32'h80 + 32'(4 * i));
    // back-pressure: requests stop once queue + outstanding reach DEPTH
    do_reset();
    {fetch_en, instr_gnt} = 2'b11;
    repeat (11) tick();
    chk("bp_grants", 32'(n_gnt), 4);
    chk("bp_req", 32'(instr_req), 0);
    chk("bp_valid", 32'(fetch_valid), 1);
    chk("bp_head", fetch_addr, 32'h80);
    fetch_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 5; i++) chk_cap("bp", i, 32'h80 + 32'(4 * i));
    // branch with two responses in flight: both are dropped
    do_reset();
    {fetch_en, instr_gnt, fetch_ready} = 3'b111;
    rsp_en = 1'b0;
    repeat (3) tick();
    chk("br_req_full", 32'(instr_req), 0);
    branch = 1'b1;
    branch_addr = 32'h1002;
    tick();
    branch = 1'b0;
    chk("br_valid", 32'(fetch_valid), 0);
    chk("br_iaddr", instr_addr, 32'h1000);
    rsp_en = 1'b1;
    repeat (8) tick();
    chk_cap("br", 0, 32'h1000);
    // grant withheld: request and address hold steady
    do_reset();
    {fetch_en, fetch_ready} = 2'b11;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("hold_req", 32'(instr_req), 1);
      chk("hold_addr", instr_addr, 32'h80);
      tick();
    end
    instr_gnt = 1'b1;
    tick();
    instr_gnt = 1'b0;
    chk("hold_next", instr_addr, 32'h84);
    repeat (6) tick();
    chk("hold_words", 32'(cap.size()), 1);
    chk_cap("hold", 0, 32'h80);
    // address wrap past the top of memory
    do_reset();
    fetch_ready = 1'b1;
    instr_gnt = 1'b1;
    branch = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    tick();
    branch = 1'b0;
    fetch_en = 1'b1;
    chk("wrap_start", instr_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_req", 32'(instr_req), 1);
    tick();
    chk("wrap_next", instr_addr, 32'h0);
    repeat (6) tick();
    chk_cap("wrap0", 0, 32'hFFFF_FFFC);
    chk_cap("wrap1", 1, 32'h0);
    // asynchronous reset with two requests outstanding
    do_reset();
    {fetch_en, instr_gnt} = 2'b11;
    rsp_en = 1'b0;
    repeat (2) tick();
    rsp_en = 1'b1;
    tick();
    rsp_en = 1'b0;
    repeat (2) tick();
    chk("ar_pre_valid", 32'(fetch_valid), 1);
    chk("ar_pre_faddr", fetch_addr, 32'h80);
    chk("ar_pre_iaddr", instr_addr, 32'h8C);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(fetch_valid), 0);
    chk("ar_rdata", fetch_rdata, 0);
    chk("ar_faddr", fetch_addr, 0);
    chk("ar_req", 32'(instr_req), 0);
    chk("ar_iaddr", instr_addr, 32'h80);
    pq.delete();
    cap.delete();
    @(negedge clk);
    rst_n = 1'b1;
    {fetch_en, instr_gnt, fetch_ready, rsp_en} = 4'b1111;
    tick();
    chk("ar_restart_req", 32'(instr_req), 1);
    chk("ar_restart_addr", instr_addr, 32'h80);
    repeat (6) tick();
    chk_cap("ar", 0, 32'h80);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
